// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD  = 4;
    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_program_loader_if.sv
// Program-memory write port driven by the loader.
interface uart_program_loader_if;
    logic        Prog_Write_o;
    logic [31:0] Prog_Address_o;
    logic [31:0] Prog_Data_o;

    modport master (output Prog_Write_o, output Prog_Address_o, output Prog_Data_o);
    modport slave  (input  Prog_Write_o, input  Prog_Address_o, input  Prog_Data_o);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling via a
// down-counting bit timer, one-cycle byte_valid / frame_err pulses.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);
    localparam int TW = $clog2(CLKS_PER_BIT);

    rx_state_e      state_q, state_d;
    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TW-1:0]  timer_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           tc, falling;

    assign tc      = (timer_q == '0);
    assign falling = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:  if (falling) state_d = RX_START;
            RX_START: if (tc) state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tc && bit_cnt_q == 3'(UART_DATA_BITS - 1)) state_d = RX_STOP;
            RX_STOP:  if (tc) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid_o = (state_q == RX_STOP) && tc && (rx_sync_q == UART_STOP_LEVEL);
        frame_err_o  = (state_q == RX_STOP) && tc && (rx_sync_q != UART_STOP_LEVEL);
        byte_o       = shift_q;
    end

    // Idle keeps the timer preloaded to half a bit so the start bit is re-checked mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (state_q == RX_IDLE)
                timer_q <= TW'(CLKS_PER_BIT / 2 - 1);
            else if (tc)
                timer_q <= TW'(CLKS_PER_BIT - 1);
            else
                timer_q <= timer_q - 1'b1;
            if (state_q == RX_START)
                bit_cnt_q <= '0;
            else if (state_q == RX_DATA && tc) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= {rx_sync_q, shift_q[7:1]};
            end
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program image over UART, writes it
// to program memory and releases the core. LOADER_CHECKSUM_EN adds an XOR trailer check.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT         = 434,
    parameter int PROGRAM_MEMORY_DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Rx_i,
    uart_program_loader_if.master   prog,
    output logic                    Core_Reset_o,
    output logic                    Load_Done_o,
    output logic                    Error_o
);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_IMAGE = CHECK;
`else
    localparam loader_state_e AFTER_IMAGE = DONE;
`endif

    loader_state_e state_q, state_d;
    logic          byte_valid, frame_err;
    logic [7:0]    rx_byte;
    logic [15:0]   n_q, word_idx_q;
    logic [15:0]   n_full;
    logic [1:0]    byte_idx_q;
    logic [23:0]   word_q;
    logic          write_q;
    logic [31:0]   addr_q, data_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (Rx_i),
        .byte_valid_o (byte_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (frame_err)
    );

    assign n_full = {rx_byte, n_q[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= CNT_LO;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CNT_LO: begin
                if (frame_err)       state_d = ERROR;
                else if (byte_valid) state_d = CNT_HI;
            end
            CNT_HI: begin
                if (frame_err) state_d = ERROR;
                else if (byte_valid) begin
                    if ({16'b0, n_full} > 32'(PROGRAM_MEMORY_DEPTH)) state_d = ERROR;
                    else if (n_full == 16'd0)                        state_d = AFTER_IMAGE;
                    else                                             state_d = DATA;
                end
            end
            DATA: begin
                if (frame_err) state_d = ERROR;
                else if (write_q && word_idx_q == n_q - 16'd1) state_d = AFTER_IMAGE;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (frame_err)       state_d = ERROR;
                else if (byte_valid) state_d = (rx_byte == csum_q) ? DONE : ERROR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        prog.Prog_Write_o   = write_q;
        prog.Prog_Address_o = addr_q;
        prog.Prog_Data_o    = data_q;
        Core_Reset_o        = (state_q != DONE);
        Load_Done_o         = (state_q == DONE);
        Error_o             = (state_q == ERROR);
    end

    // The first three bytes of a word collect in word_q; the fourth completes it straight into data_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            write_q <= 1'b0;
            if (byte_valid && state_q == CNT_LO) n_q[7:0]  <= rx_byte;
            if (byte_valid && state_q == CNT_HI) n_q[15:8] <= rx_byte;
            if (byte_valid && state_q == DATA) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                word_q     <= {rx_byte, word_q[23:8]};
                if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                    write_q <= 1'b1;
                    data_q  <= {rx_byte, word_q};
                    addr_q  <= {14'b0, word_idx_q, 2'b00};
                end
            end
            if (write_q) word_idx_q <= word_idx_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            if (byte_valid && (state_q == CNT_LO || state_q == CNT_HI || state_q == DATA))
                csum_q <= csum_q ^ rx_byte;
`endif
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed and randomized image loads against a byte-stream reference model.
module tb_uart_program_loader;
    localparam int CPB   = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic core_rst, done, err;

    uart_program_loader_if prog_if();

    uart_program_loader #(.CLKS_PER_BIT(CPB), .PROGRAM_MEMORY_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .Rx_i         (rx),
        .prog         (prog_if),
        .Core_Reset_o (core_rst),
        .Load_Done_o  (done),
        .Error_o      (err)
    );

    always #5 clk = ~clk;

    int          n_pass = 0, n_fail = 0, n_total = 0;
    int          cyc = 0, consec = 0, last_wr_cyc = 0, done_cyc = -1, stop_cyc = 0;
    logic        prev_wr = 1'b0;
    logic [63:0] got_w[$];
    logic [63:0] exp_w[$];
    logic [8:0]  stream[$];   // {stop_bit, data}
    bit          exp_done, exp_err;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (prog_if.Prog_Write_o) begin
                got_w.push_back({prog_if.Prog_Address_o, prog_if.Prog_Data_o});
                if (prev_wr) consec++;
                last_wr_cyc = cyc;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
        end
        prev_wr = prog_if.Prog_Write_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [8:0] sb);
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(sb[i]);
        stop_cyc = cyc;
        hold(sb[8]);
        hold(1'b1);
        hold(1'b1);
    endtask

    task automatic pb(input logic [7:0] b);
        stream.push_back({1'b1, b});
    endtask

    // Parse the byte stream the way the loader is described: count, words, optional trailer.
    task automatic model();
        int n, pos;
        logic [7:0]  x;
        logic [31:0] word;
        exp_w.delete();
        exp_done = 0;
        exp_err  = 0;
        if (stream.size() < 2) return;
        if (!stream[0][8] || !stream[1][8]) begin exp_err = 1; return; end
        n = int'({stream[1][7:0], stream[0][7:0]});
        if (n > DEPTH) begin exp_err = 1; return; end
        x = stream[0][7:0] ^ stream[1][7:0];
        for (int w = 0; w < n; w++) begin
            word = 0;
            for (int b = 0; b < 4; b++) begin
                pos = 2 + 4 * w + b;
                if (pos >= stream.size()) return;
                if (!stream[pos][8]) begin exp_err = 1; return; end
                word = word | (32'(stream[pos][7:0]) << (8 * b));
                x = x ^ stream[pos][7:0];
            end
            exp_w.push_back({32'(w * 4), word});
        end
`ifdef LOADER_CHECKSUM_EN
        pos = 2 + 4 * n;
        if (pos >= stream.size()) return;
        if (!stream[pos][8] || stream[pos][7:0] != x) begin exp_err = 1; return; end
`endif
        exp_done = 1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check({tag, "/rst_wr"},   32'(prog_if.Prog_Write_o), 32'd0);
        check({tag, "/rst_addr"}, prog_if.Prog_Address_o, 32'd0);
        check({tag, "/rst_data"}, prog_if.Prog_Data_o, 32'd0);
        check({tag, "/rst_core"}, 32'(core_rst), 32'd1);
        check({tag, "/rst_done"}, 32'(done), 32'd0);
        check({tag, "/rst_err"},  32'(err), 32'd0);
        @(posedge clk);
        #1;
        got_w.delete();
        consec   = 0;
        done_cyc = -1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_case(input string tag);
        int n;
        do_reset(tag);
        model();
        foreach (stream[i]) send_byte(stream[i]);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "/wr_count"}, got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s/addr%0d", tag, i), got_w[i][63:32], exp_w[i][63:32]);
            check($sformatf("%s/data%0d", tag, i), got_w[i][31:0], exp_w[i][31:0]);
        end
        check({tag, "/done"},     32'(done), 32'(exp_done));
        check({tag, "/error"},    32'(err), 32'(exp_err));
        check({tag, "/core_rst"}, 32'(core_rst), 32'(!exp_done));
        check({tag, "/b2b_wr"},   consec, 0);
        if (exp_done && exp_w.size() > 0)
            check({tag, "/done_lat"}, done_cyc - last_wr_cyc, 1);
    endtask

    initial begin
        logic [7:0]  x;
        logic [31:0] w;
        int          n, fe;
        repeat (3) @(posedge clk);

        stream.delete();
        pb(8'h02); pb(8'h00); pb(8'h93); pb(8'h00); pb(8'h50); pb(8'h00);
        pb(8'h33); pb(8'h81); pb(8'h10); pb(8'h00);
`ifdef LOADER_CHECKSUM_EN
        pb(8'h02 ^ 8'h93 ^ 8'h50 ^ 8'h33 ^ 8'h81 ^ 8'h10);
`endif
        run_case("two_words");

        stream.delete();
        pb(8'h00); pb(8'h00);
`ifdef LOADER_CHECKSUM_EN
        pb(8'h00);
`endif
        run_case("zero_words");
        check("zero_words/done_window",
              32'(done_cyc > stop_cyc && done_cyc <= stop_cyc + 8), 32'd1);

        stream.delete();
        pb(8'h41); pb(8'h00);
        for (int i = 0; i < 4; i++) pb(8'($urandom));
        run_case("oversize65");

        stream.delete();
        pb(8'h01); pb(8'h00); stream.push_back({1'b0, 8'($urandom)});
        run_case("frame_err");

        stream.delete();
        pb(8'h02); pb(8'h00); pb(8'h11); pb(8'h22); pb(8'h33); pb(8'h44);
        run_case("partial");
        stream.delete();
        pb(8'h01); pb(8'h00); pb(8'hEF); pb(8'hBE); pb(8'hAD); pb(8'hDE);
`ifdef LOADER_CHECKSUM_EN
        pb(8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`endif
        run_case("after_reset");

`ifdef LOADER_CHECKSUM_EN
        stream.delete();
        pb(8'h01); pb(8'h00); pb(8'h13); pb(8'h00); pb(8'h00); pb(8'h00); pb(8'h12);
        run_case("csum_ok");
        stream.delete();
        pb(8'h01); pb(8'h00); pb(8'h13); pb(8'h00); pb(8'h00); pb(8'h00); pb(8'h00);
        run_case("csum_bad");
`endif

        for (int k = 0; k < 6; k++) begin
            stream.delete();
            n = $urandom_range(1, 5);
            pb(8'(n)); pb(8'h00);
            x = 8'(n);
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                for (int b = 0; b < 4; b++) begin
                    pb(w[8*b +: 8]);
                    x = x ^ w[8*b +: 8];
                end
            end
`ifdef LOADER_CHECKSUM_EN
            pb(((k % 3) == 1) ? ~x : x);
`endif
            pb(8'($urandom));
            if ((k % 3) == 2) begin
                fe = $urandom_range(0, stream.size() - 1);
                stream[fe][8] = 1'b0;
            end
            run_case($sformatf("rand%0d", k));
        end

        stream.delete();
        n = $urandom_range(DEPTH + 1, 65535);
        pb(8'(n)); pb(8'(n >> 8));
        for (int i = 0; i < 4; i++) pb(8'($urandom));
        run_case("rand_oversize");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
